// File: rtl/bcd_adder_2digit_pkg.sv
// Shared constants and types for the two-digit packed-BCD adder.
package bcd_adder_2digit_pkg;

    // Width of one BCD digit (nibble)
    localparam int BCD_DIGIT_W   = 4;

    // Added to a binary digit sum above 9 to wrap it back into BCD range
    localparam int BCD_CORRECTION = 6;

    // Largest legal value of a BCD digit
    localparam int BCD_MAX_DIGIT  = 9;

    // One packed-BCD byte: tens digit in the upper nibble, units in the lower
    typedef struct packed {
        logic [BCD_DIGIT_W-1:0] tens;
        logic [BCD_DIGIT_W-1:0] units;
    } bcd_byte_t;

endpackage

// File: rtl/bcd_adder_2digit_if.sv
// Operand/result bundle for the two-digit BCD adder.
// The master side drives the operands and reads the result;
// the slave side is the adder itself.
interface bcd_adder_2digit_if;
    import bcd_adder_2digit_pkg::*;

    logic      in_valid;
    bcd_byte_t A;
    bcd_byte_t B;
    logic      Cin;
    logic      out_valid;
    bcd_byte_t S;
    logic      Cout;
    logic      digit_err;

    modport master (
        output in_valid, A, B, Cin,
        input  out_valid, S, Cout, digit_err
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output out_valid, S, Cout, digit_err
    );

endinterface

// File: rtl/bcd_adder_2digit_digit_adder.sv
// Combinational single-digit BCD adder with decimal carry in/out.
// Non-BCD operand digits still go through the same correction and
// raise o_err so the caller can flag the result.
module bcd_digit_adder
    import bcd_adder_2digit_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_a,
    input  logic [BCD_DIGIT_W-1:0] i_b,
    input  logic                   i_cin,
    output logic [BCD_DIGIT_W-1:0] o_sum,
    output logic                   o_cout,
    output logic                   o_err
);

    logic [BCD_DIGIT_W:0] w_binSum;
    logic [BCD_DIGIT_W:0] w_corrSum;

    assign w_binSum  = {1'b0, i_a} + {1'b0, i_b} + {{BCD_DIGIT_W{1'b0}}, i_cin};
    assign w_corrSum = w_binSum + (BCD_DIGIT_W+1)'(BCD_CORRECTION);

    // Sums above 9 wrap by adding 6 (keeping the low nibble) and carry into the next digit
    always_comb begin
        o_sum  = w_binSum[BCD_DIGIT_W-1:0];
        o_cout = 1'b0;
        if (w_binSum > (BCD_DIGIT_W+1)'(BCD_MAX_DIGIT)) begin
            o_sum  = w_corrSum[BCD_DIGIT_W-1:0];
            o_cout = 1'b1;
        end
    end

    assign o_err = (i_a > BCD_DIGIT_W'(BCD_MAX_DIGIT)) ||
                   (i_b > BCD_DIGIT_W'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_adder_2digit.sv
// Registered two-digit packed-BCD adder: S/Cout = A + B + Cin in decimal,
// one cycle of latency, full throughput, non-BCD inputs flagged on digit_err.
module bcd_adder_2digit
    import bcd_adder_2digit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    bcd_adder_2digit_if.slave     bus
);

    bcd_byte_t w_sum;
    logic      w_unitsCarry;
    logic      w_tensCarry;
    logic      w_unitsErr;
    logic      w_tensErr;

    bcd_byte_t r_sum;
    logic      r_cout;
    logic      r_err;
    logic      r_valid;

    bcd_digit_adder u_units (
        .i_a    (bus.A.units),
        .i_b    (bus.B.units),
        .i_cin  (bus.Cin),
        .o_sum  (w_sum.units),
        .o_cout (w_unitsCarry),
        .o_err  (w_unitsErr)
    );

    bcd_digit_adder u_tens (
        .i_a    (bus.A.tens),
        .i_b    (bus.B.tens),
        .i_cin  (w_unitsCarry),
        .o_sum  (w_sum.tens),
        .o_cout (w_tensCarry),
        .o_err  (w_tensErr)
    );

    // Capture the sum on accepted operations; an idle cycle drops valid but keeps the last result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= 8'h00;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_tensCarry;
                r_err  <= w_unitsErr | w_tensErr;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.S         = r_sum;
    assign bus.Cout      = r_cout;
    assign bus.digit_err = r_err;

endmodule

// File: tb/tb_bcd_adder_2digit.sv
// Self-checking bench for bcd_adder_2digit: directed cases plus random
// operands, compared against a decimal-arithmetic reference model.
module tb_bcd_adder_2digit;
    import bcd_adder_2digit_pkg::*;

    logic clk;
    logic rst;
    bcd_adder_2digit_if bus ();

    int errors;
    int checks;

    // Expected outputs after the most recent edge
    logic       expValid;
    logic [7:0] expS;
    logic       expCout;
    logic       expErr;
    logic       expKnown;
    logic       pending;

    bcd_adder_2digit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decimal reference: treat each byte as a two-digit number, add, split back into digits
    function automatic void refAdd(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                   output logic [7:0] s, output logic cout,
                                   output logic err, output logic known);
        int da;
        int db;
        int total;
        err   = (a[7:4] > 4'd9) || (a[3:0] > 4'd9) || (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
        known = !err;
        da    = int'(a[7:4]) * 10 + int'(a[3:0]);
        db    = int'(b[7:4]) * 10 + int'(b[3:0]);
        total = da + db + int'(cin);
        cout  = (total >= 100);
        total = total % 100;
        s     = {4'(total / 10), 4'(total % 10)};
    endfunction

    task automatic checkOutput();
        checks++;
        assert (bus.out_valid === expValid) else begin
            errors++;
            $error("[TB] FAIL out_valid: observed=%b expected=%b", bus.out_valid, expValid);
        end
        checks++;
        assert (bus.digit_err === expErr) else begin
            errors++;
            $error("[TB] FAIL digit_err: observed=%b expected=%b", bus.digit_err, expErr);
        end
        if (expKnown) begin
            checks++;
            assert (bus.S === expS) else begin
                errors++;
                $error("[TB] FAIL S: observed=%h expected=%h", bus.S, expS);
            end
            checks++;
            assert (bus.Cout === expCout) else begin
                errors++;
                $error("[TB] FAIL Cout: observed=%b expected=%b", bus.Cout, expCout);
            end
        end
    endtask

    // Check the previous step's result, then drive one new cycle of inputs and predict its effect
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] a,
                                 input logic [7:0] b, input logic c);
        logic [7:0] s;
        logic       co;
        logic       er;
        logic       kn;
        @(negedge clk);
        if (pending) checkOutput();
        rst          = r;
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = c;
        if (r) begin
            expValid = 1'b0;
            expS     = 8'h00;
            expCout  = 1'b0;
            expErr   = 1'b0;
            expKnown = 1'b1;
        end else if (v) begin
            refAdd(a, b, c, s, co, er, kn);
            expValid = 1'b1;
            expS     = s;
            expCout  = co;
            expErr   = er;
            expKnown = kn;
        end else begin
            expValid = 1'b0;
        end
        pending = 1'b1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        errors       = 0;
        checks       = 0;
        pending      = 1'b0;
        expKnown     = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.A        = 8'h00;
        bus.B        = 8'h00;
        bus.Cin      = 1'b0;

        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h55, 8'h44, 1'b1);

        applyStimulus(1'b0, 1'b1, 8'h29, 8'h41, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h70, 8'h93, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h20, 8'h56, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h79, 8'h09, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h32, 8'h65, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h99, 8'h99, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h99, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h0A, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h11, 8'h11, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h45, 8'h45, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h88, 8'h77, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h99, 8'h99, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h50, 8'h49, 1'b1);

        for (int i = 0; i < 60; i++) begin
            ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if ($urandom_range(0, 9) == 0) ra[3:0] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) rb[7:4] = 4'($urandom_range(10, 15));
            applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                          ra, rb, 1'($urandom_range(0, 1)));
        end

        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
